sd_model_loader: RTL and testbench
==================================

// Module: sd_model_loader
// PURPOSE
//  Downstream consumer of the SD-card SPI controller. Issues one sector read at a time
//  (rd_start_en / rd_sec_addr), packs the 16-bit read stream into 32-bit words, buffers
//  them in a small FIFO, and writes them to model memory over a valid/ready port. The
//  model loader instantiates it to copy load_sec_cnt consecutive sectors into on-chip RAM.
// PARAMETERS
//  ADDR_W      16    model-memory word-address width
//  FIFO_DEPTH  8     32-bit word FIFO depth (power of 2, >=2)
//  HALF_ORDER  0     0: first halfword -> [15:0]; 1: first halfword -> [31:16]
//  BUSY_TO     1024  cycles to wait for rd_busy rise after rd_start_en before error
// PORTS
//  clk_ref        in   1       clock (same clock as SD controller)
//  rst_n          in   1       asynchronous reset, active low
//  sd_init_done   in   1       SD card initialised
//  load_start     in   1       1-cycle pulse: start job (ignored unless idle)
//  load_base_sec  in   32      first sector address
//  load_sec_cnt   in   16      number of sectors (0 allowed)
//  load_busy      out  1       job in progress
//  load_done      out  1       1-cycle pulse at job end (success or error)
//  load_err       out  1       sticky error flag, cleared on next accepted load_start
//  rd_start_en    out  1       1-cycle sector read request to SD controller
//  rd_sec_addr    out  32      sector address, stable from request until rd_busy falls
//  rd_busy        in   1       SD controller read busy
//  rd_val_en      in   1       halfword valid (cannot be stalled)
//  rd_val_data    in   16      halfword data
//  mem_wr_en      out  1       write valid
//  mem_wr_addr    out  ADDR_W  word address
//  mem_wr_data    out  32      packed word
//  mem_wr_ready   in   1       write accepted when mem_wr_en & mem_wr_ready
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, word address 0, pack-phase 0.
//  FSM: IDLE -> (load_start) latch base/cnt, clear err, addr<=0 -> WAIT_INIT if !sd_init_done,
//   else REQ; cnt==0 -> DONE directly (no requests, no writes).
//   WAIT_INIT -> REQ when sd_init_done.  REQ: rd_start_en=1 for exactly one cycle,
//   rd_sec_addr=base+idx (mod 2^32) -> WAIT_BUSY.  WAIT_BUSY: rd_busy=1 -> XFER; BUSY_TO
//   cycles w/o rise -> err, DRAIN.  XFER: count halfwords; rd_busy falls -> if count!=256
//   err, DRAIN; else idx+1; idx==cnt -> DRAIN else REQ (next cycle).
//   DRAIN: wait FIFO empty -> DONE.  DONE: load_done=1 one cycle -> IDLE.
//  load_busy=1 in every state except IDLE; it drops the cycle after load_done.
//  Packing: phase toggles per rd_val_en; second halfword completes word, pushed same cycle;
//   phase resets to 0 at each REQ (a dangling odd halfword is discarded; count check flags it).
//  FIFO push while full: word dropped, err set, transfer continues to sector end, then DRAIN.
//  Simultaneous push/pop when full: allowed, no overflow.
//  Write port: mem_wr_en = FIFO not empty; data = FIFO head; addr increments by 1 per
//   accepted write, wraps at 2^ADDR_W. Unaccepted write holds addr/data stable.
//  rd_val_en outside XFER: ignored. load_start while busy: ignored.
//  Async reset mid-job: immediate return to reset state; no load_done.
// STRUCTURE
//  Package sd_loader_pkg: SEC_HALFWORDS=256, state encoding localparams.
//  Sub-module sd_loader_fifo: synchronous 32-bit FIFO, FIFO_DEPTH, full/empty flags.
//  Top: FSM, sector index/halfword counters, packer, timeout counter, address counter.
// TESTING
//  base=0x100,cnt=1, halfwords 0x1111,0x2222,... ready=1 -> one rd_start_en, rd_sec_addr=0x100,
//   128 writes addr 0..127, word0=0x22221111 (HALF_ORDER=0), load_done, err=0.
//  base=0xFFFFFFFF,cnt=3, ready random 50% -> addrs 0xFFFFFFFF,0,1; 384 writes in order, err=0.
//  cnt=0 -> load_done 2 cycles after load_start, no rd_start_en, no writes.
//  Sector ends after 255 halfwords -> err=1, load_done, no further rd_start_en.
//  ready=0 for full sector -> FIFO_DEPTH words held, overflow err=1, those 8 written after ready=1.
//  sd_init_done low 50 cycles then high -> first rd_start_en follows; rst_n low mid-XFER -> all outputs 0.

Source files
------------

// File: rtl/sd_loader_pkg.sv
// Shared constants for the SD-card model loader: sector geometry and FSM encoding.
package sd_loader_pkg;

  localparam int SEC_HALFWORDS = 256;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_INIT = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_XFER      = 3'd4;
  localparam logic [2:0] ST_DRAIN     = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

endpackage

// File: rtl/sd_loader_fifo.sv
// Synchronous word FIFO between the halfword packer and the model-memory write port.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sd_loader_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  // Head reads as zero when empty so the write-data port is quiet out of reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/sd_model_loader.sv
// Copies load_sec_cnt consecutive SD sectors into model memory: one sector read at a
// time, 16->32 bit packing, FIFO buffering, valid/ready write port (accept = en & ready).
module sd_model_loader
  import sd_loader_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int HALF_ORDER = 0,
  parameter int BUSY_TO    = 1024
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              sd_init_done,
  input  logic              load_start,
  input  logic [31:0]       load_base_sec,
  input  logic [15:0]       load_sec_cnt,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic              rd_start_en,
  output logic [31:0]       rd_sec_addr,
  input  logic              rd_busy,
  input  logic              rd_val_en,
  input  logic [15:0]       rd_val_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ready,
  output logic [2:0]        dbg_state
);
  localparam int TO_W = $clog2(BUSY_TO + 1);

  logic [2:0]        r_state;
  logic [31:0]       r_base;
  logic [15:0]       r_cnt;
  logic [15:0]       r_idx;
  logic [9:0]        r_hw_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_phase;
  logic [15:0]       r_half;
  logic              r_err;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_wr_addr;

  logic        w_xfer_val;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf;
  logic        w_sec_ok;
  logic [31:0] w_word;
  logic [31:0] w_rdata;
  logic [9:0]  w_hw_nxt;
  logic [15:0] w_idx_nxt;

  assign w_xfer_val = (r_state == ST_XFER) && rd_val_en;
  assign w_push     = w_xfer_val && r_phase;
  assign w_word     = (HALF_ORDER != 0) ? {r_half, rd_val_data} : {rd_val_data, r_half};
  assign w_pop      = !w_empty && mem_wr_ready;
  assign w_ovf      = w_push && w_full && !w_pop;
  // Saturating halfword count so an over-long sector cannot wrap back to a "good" value.
  assign w_hw_nxt   = (w_xfer_val && (r_hw_cnt != '1)) ? r_hw_cnt + 10'd1 : r_hw_cnt;
  assign w_sec_ok   = (w_hw_nxt == 10'(SEC_HALFWORDS));
  assign w_idx_nxt  = r_idx + 16'd1;

  sd_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk_ref),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_hw_cnt  <= '0;
      r_to_cnt  <= '0;
      r_phase   <= 1'b0;
      r_half    <= '0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      if (w_pop) r_wr_addr <= r_wr_addr + 1'b1;
      if (w_ovf) begin
        r_err <= 1'b1;
        r_ovf <= 1'b1;
      end
      if (w_xfer_val) begin
        r_phase  <= ~r_phase;
        r_hw_cnt <= w_hw_nxt;
        if (!r_phase) r_half <= rd_val_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_base    <= load_base_sec;
            r_cnt     <= load_sec_cnt;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_wr_addr <= '0;
            if (load_sec_cnt == 16'd0) r_state <= ST_DONE;
            else if (!sd_init_done)    r_state <= ST_WAIT_INIT;
            else                       r_state <= ST_REQ;
          end
        end
        ST_WAIT_INIT: if (sd_init_done) r_state <= ST_REQ;
        ST_REQ: begin
          r_phase  <= 1'b0;
          r_hw_cnt <= '0;
          r_to_cnt <= '0;
          r_state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (rd_busy) begin
            r_state <= ST_XFER;
          end else if (r_to_cnt == TO_W'(BUSY_TO - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_DRAIN;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          // rd_busy low here means the sector has ended.
          if (!rd_busy) begin
            if (!w_sec_ok) begin
              r_err   <= 1'b1;
              r_state <= ST_DRAIN;
            end else if (r_ovf || w_ovf) begin
              r_state <= ST_DRAIN;
            end else begin
              r_idx   <= w_idx_nxt;
              r_state <= (w_idx_nxt == r_cnt) ? ST_DRAIN : ST_REQ;
            end
          end
        end
        ST_DRAIN: if (w_empty) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_busy   = (r_state != ST_IDLE);
  assign load_done   = (r_state == ST_DONE);
  assign load_err    = r_err;
  assign rd_start_en = (r_state == ST_REQ);
  assign rd_sec_addr = r_base + {16'd0, r_idx};
  assign mem_wr_en   = !w_empty;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = w_rdata;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sd_model_loader.sv
// Directed bench for sd_model_loader: an SD read-stream driver, a write-port monitor and
// per-scenario tasks comparing observed requests/writes against bench-built expectations.
module tb_sd_model_loader;
  import sd_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sd_init_done;
  logic        load_start;
  logic [31:0] load_base_sec;
  logic [15:0] load_sec_cnt;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        rd_val_en;
  logic [15:0] rd_val_data;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready
  int n_req;
  int n_done;
  logic [31:0] exp_q[$];
  logic [31:0] wd_q[$];
  logic [15:0] wa_q[$];
  logic [31:0] ra_q[$];

  sd_model_loader dut (
    .clk_ref       (clk),
    .rst_n         (rst_n),
    .sd_init_done  (sd_init_done),
    .load_start    (load_start),
    .load_base_sec (load_base_sec),
    .load_sec_cnt  (load_sec_cnt),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .load_err      (load_err),
    .rd_start_en   (rd_start_en),
    .rd_sec_addr   (rd_sec_addr),
    .rd_busy       (rd_busy),
    .rd_val_en     (rd_val_en),
    .rd_val_data   (rd_val_data),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ready  (mem_wr_ready),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       mem_wr_ready = 1'b1;
        1:       mem_wr_ready = 1'($urandom_range(0, 1));
        default: mem_wr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: requests, done pulses and accepted writes, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_start_en) begin
        n_req++;
        ra_q.push_back(rd_sec_addr);
      end
      if (load_done) n_done++;
      if (mem_wr_en && mem_wr_ready) begin
        wa_q.push_back(mem_wr_addr);
        wd_q.push_back(mem_wr_data);
      end
    end
  end

  // Driver tasks
  task automatic clear_mon();
    n_req = 0;
    n_done = 0;
    exp_q.delete();
    wd_q.delete();
    wa_q.delete();
    ra_q.delete();
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] cnt);
    @(posedge clk); #1;
    load_base_sec = base;
    load_sec_cnt  = cnt;
    load_start    = 1'b1;
    @(posedge clk); #1;
    load_start    = 1'b0;
  endtask

  // Serves one sector read: halfword i of the sector carries (i+1)*0x1111.
  task automatic sd_serve(input int n_half, input int gap, output bit ok);
    logic [15:0] hw;
    logic [15:0] prev;
    ok = 1'b0;
    prev = '0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (rd_start_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    @(posedge clk); #1 rd_busy = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < n_half; i++) begin
      hw = 16'((i + 1) * 32'h1111);
      rd_val_en   = 1'b1;
      rd_val_data = hw;
      if (i % 2 == 1) exp_q.push_back({hw, prev});
      prev = hw;
      @(posedge clk); #1 rd_val_en = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    rd_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({load_busy, load_done, load_err, rd_start_en, mem_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 00000",
               {load_busy, load_done, load_err, rd_start_en, mem_wr_en});
    end
    checks++;
    if ({rd_sec_addr, mem_wr_addr, mem_wr_data} !== 80'd0) begin
      errors++;
      $display("FAIL reset_buses got %h/%h/%h expected 0", rd_sec_addr, mem_wr_addr, mem_wr_data);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_sector();
    bit ok;
    clear_mon();
    ready_mode = 0;
    start_job(32'h100, 16'd1);
    sd_serve(256, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_req no rd_start_en seen"); end
    wait_done(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done load_done not seen"); end
    checks++;
    if (load_busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_done got %b expected 1", load_busy); end
    @(negedge clk);
    checks++;
    if (load_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b expected 0", load_busy); end
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL single_err got %b expected 0", load_err); end
    checks++;
    if (n_req != 1 || ra_q.size() != 1 || ra_q[0] !== 32'h100) begin
      errors++;
      $display("FAIL single_sec_addr got %0d reqs first %h expected 1 req at 100", n_req,
               (ra_q.size() > 0) ? ra_q[0] : 32'hx);
    end
    checks++;
    if (wd_q.size() != 128) begin errors++; $display("FAIL single_count got %0d expected 128", wd_q.size()); end
    checks++;
    if (wd_q.size() > 0 && wd_q[0] !== 32'h22221111) begin
      errors++;
      $display("FAIL single_word0 got %h expected 22221111", wd_q[0]);
    end
    for (int i = 0; i < wd_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (wd_q[i] !== exp_q[i] || wa_q[i] !== 16'(i)) begin
        errors++;
        $display("FAIL single_write[%0d] got %h@%h expected %h@%h", i, wd_q[i], wa_q[i], exp_q[i], 16'(i));
      end
    end
  endtask

  task automatic test_zero_cnt();
    clear_mon();
    @(posedge clk); #1;
    load_base_sec = 32'h55;
    load_sec_cnt  = 16'd0;
    load_start    = 1'b1;
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0) begin errors++; $display("FAIL zero_done_early got %b expected 0", load_done); end
    @(posedge clk); #1 load_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_done, load_busy} !== 2'b11) begin
      errors++;
      $display("FAIL zero_done_pulse got done/busy %b expected 11", {load_done, load_busy});
    end
    @(negedge clk);
    checks++;
    if ({load_done, load_busy} !== 2'b00) begin
      errors++;
      $display("FAIL zero_idle got done/busy %b expected 00", {load_done, load_busy});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (n_req != 0 || wd_q.size() != 0 || n_done != 1) begin
      errors++;
      $display("FAIL zero_activity got req %0d writes %0d done %0d expected 0 0 1", n_req, wd_q.size(), n_done);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFFF;
    exp_addr[1] = 32'h0;
    exp_addr[2] = 32'h1;
    clear_mon();
    ready_mode = 1;
    start_job(32'hFFFF_FFFF, 16'd3);
    for (int s = 0; s < 3; s++) begin
      sd_serve(256, 3, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_req[%0d] no rd_start_en seen", s); end
    end
    wait_done(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_done load_done not seen"); end
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b expected 0", load_err); end
    checks++;
    if (ra_q.size() != 3) begin errors++; $display("FAIL wrap_nreq got %0d expected 3", ra_q.size()); end
    for (int s = 0; s < ra_q.size() && s < 3; s++) begin
      checks++;
      if (ra_q[s] !== exp_addr[s]) begin
        errors++;
        $display("FAIL wrap_sec_addr[%0d] got %h expected %h", s, ra_q[s], exp_addr[s]);
      end
    end
    checks++;
    if (wd_q.size() != 384) begin errors++; $display("FAIL wrap_count got %0d expected 384", wd_q.size()); end
    for (int i = 0; i < wd_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (wd_q[i] !== exp_q[i] || wa_q[i] !== 16'(i)) begin
        errors++;
        $display("FAIL wrap_write[%0d] got %h@%h expected %h@%h", i, wd_q[i], wa_q[i], exp_q[i], 16'(i));
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_short_sector();
    bit ok;
    clear_mon();
    start_job(32'h5, 16'd3);
    sd_serve(255, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL short_req no rd_start_en seen"); end
    wait_done(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL short_done load_done not seen"); end
    checks++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL short_err got %b expected 1", load_err); end
    repeat (10) @(negedge clk);
    checks++;
    if (n_req != 1) begin errors++; $display("FAIL short_nreq got %0d expected 1", n_req); end
    checks++;
    if (wd_q.size() != 127) begin errors++; $display("FAIL short_count got %0d expected 127", wd_q.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_mon();
    ready_mode = 2;
    start_job(32'h300, 16'd1);
    sd_serve(256, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_req no rd_start_en seen"); end
    repeat (5) @(negedge clk);
    checks++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b expected 1", load_err); end
    checks++;
    if ({mem_wr_en, load_busy} !== 2'b11 || n_done != 0) begin
      errors++;
      $display("FAIL ovf_hold got en/busy %b done %0d expected 11 0", {mem_wr_en, load_busy}, n_done);
    end
    checks++;
    if (mem_wr_data !== exp_q[0] || mem_wr_addr !== 16'd0) begin
      errors++;
      $display("FAIL ovf_head got %h@%h expected %h@0", mem_wr_data, mem_wr_addr, exp_q[0]);
    end
    ready_mode = 0;
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_done load_done not seen"); end
    checks++;
    if (wd_q.size() != 8) begin errors++; $display("FAIL ovf_count got %0d expected 8", wd_q.size()); end
    for (int i = 0; i < wd_q.size() && i < 8; i++) begin
      checks++;
      if (wd_q[i] !== exp_q[i] || wa_q[i] !== 16'(i)) begin
        errors++;
        $display("FAIL ovf_write[%0d] got %h@%h expected %h@%h", i, wd_q[i], wa_q[i], exp_q[i], 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int done_before;
    clear_mon();
    start_job(32'h40, 16'd2);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = (rd_start_en === 1'b1);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_req no rd_start_en seen"); end
    @(posedge clk); #1 rd_busy = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 40; i++) begin
      rd_val_en   = 1'b1;
      rd_val_data = 16'(i * 3 + 7);
      @(posedge clk); #1;
    end
    done_before = n_done;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({load_busy, load_done, load_err, rd_start_en, mem_wr_en} !== 5'b0 ||
        {rd_sec_addr, mem_wr_addr, mem_wr_data} !== 80'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got flags %b buses %h/%h/%h expected all 0",
               {load_busy, load_done, load_err, rd_start_en, mem_wr_en}, rd_sec_addr, mem_wr_addr, mem_wr_data);
    end
    rd_val_en = 1'b0;
    rd_busy   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_done != done_before || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rstmid_nodone got done %0d state %0d expected %0d %0d", n_done, dbg_state, done_before, ST_IDLE);
    end
  endtask

  task automatic test_wait_init();
    bit ok;
    clear_mon();
    sd_init_done = 1'b0;
    start_job(32'h20, 16'd1);
    repeat (20) @(negedge clk);
    start_job(32'h999, 16'd0);  // must be ignored while busy
    repeat (30) @(negedge clk);
    checks++;
    if (n_req != 0 || dbg_state !== ST_WAIT_INIT || n_done != 0) begin
      errors++;
      $display("FAIL init_wait got req %0d state %0d done %0d expected 0 %0d 0", n_req, dbg_state, n_done, ST_WAIT_INIT);
    end
    @(posedge clk); #1 sd_init_done = 1'b1;
    sd_serve(256, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_req no rd_start_en seen"); end
    wait_done(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_done load_done not seen"); end
    checks++;
    if (ra_q.size() != 1 || ra_q[0] !== 32'h20 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL init_sec_addr got %0d reqs first %h err %b expected 1 req at 20 err 0", ra_q.size(),
               (ra_q.size() > 0) ? ra_q[0] : 32'hx, load_err);
    end
    checks++;
    if (wd_q.size() != 128 || (wd_q.size() > 0 && wd_q[127] !== exp_q[127])) begin
      errors++;
      $display("FAIL init_writes got %0d words expected 128 ending %h", wd_q.size(), exp_q[127]);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    sd_init_done  = 1'b1;
    load_start    = 1'b0;
    load_base_sec = '0;
    load_sec_cnt  = '0;
    rd_busy       = 1'b0;
    rd_val_en     = 1'b0;
    rd_val_data   = '0;
    clear_mon();
    test_reset();
    test_single_sector();
    test_zero_cnt();
    test_wrap();
    test_short_sector();
    test_overflow();
    test_reset_mid();
    test_wait_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
